// File: rtl/tile_data_feeder.sv
// tile_data_feeder
// Responder side of the systolic-array operand-fetch handshake. After a job
// start it raises data_valid; every read_data cycle it fetches one element of
// A and one of B from the operand SRAMs, walking tiles column-then-row, and
// returns them one cycle later with out_valid. Partial edge tiles are
// zero-padded per operand; all_done pulses once the last element is returned.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle job start pulse (ignored while busy)
//   read_data                  per-element fetch request from the controller
//   data_valid                 operands ready, controller may begin loading
//   mem_rd_en                  shared A/B SRAM read enable
//   mem_addr_a, mem_addr_b     SRAM addresses (0 for a padded operand)
//   mem_rdata_a, mem_rdata_b   SRAM read data, one cycle after mem_rd_en
//   a_out, b_out, out_valid    returned operand pair
//   tile_col_idx, tile_row_idx current K- and M-direction tile indices
//   busy                       job in progress
//   all_done                   one-cycle completion pulse
module tile_data_feeder #(
  parameter int DATA_W = 8,
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4,
  parameter int M_SIZE = 4,
  parameter int K_SIZE = 16,
  parameter int N_SIZE = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              read_data,
  output logic              data_valid,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [ADDR_W-1:0] mem_addr_b,
  input  logic [DATA_W-1:0] mem_rdata_a,
  input  logic [DATA_W-1:0] mem_rdata_b,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              out_valid,
  output logic [4:0]        tile_col_idx,
  output logic [4:0]        tile_row_idx,
  output logic              busy,
  output logic              all_done
);

  localparam int TILE_ELEMS = WIDTH * HEIGHT;
  localparam int TC         = (K_SIZE + WIDTH - 1) / WIDTH;
  localparam int TR         = (M_SIZE + HEIGHT - 1) / HEIGHT;
  localparam int EW         = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;

  typedef enum logic [2:0] {IDLE, ARM, STREAM, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [EW-1:0]     elem_cnt, elem_nx;
  logic [4:0]        col_nx, row_nx;
  logic              serviced, pad_a, pad_b, pad_a_q, pad_b_q;
  logic              last_elem, last_col, last_row;
  logic [31:0]       e_r, e_c, a_row, a_col, b_row;
  logic [DATA_W-1:0] a_hold, b_hold;

  // Element coordinates and padding decisions for the element being serviced.
  always_comb begin
    e_r   = 32'(elem_cnt) / WIDTH;
    e_c   = 32'(elem_cnt) % WIDTH;
    a_row = 32'(tile_row_idx) * HEIGHT + e_r;
    a_col = 32'(tile_col_idx) * WIDTH + e_c;
    b_row = 32'(tile_col_idx) * WIDTH + e_r;
    pad_a = !((a_row < M_SIZE) && (a_col < K_SIZE));
    pad_b = !((b_row < K_SIZE) && (e_c < N_SIZE));

    serviced   = read_data && ((state == ARM) || (state == STREAM));
    mem_rd_en  = serviced && !(pad_a && pad_b);
    mem_addr_a = (serviced && !pad_a) ? ADDR_W'(a_row * K_SIZE + a_col) : '0;
    mem_addr_b = (serviced && !pad_b) ? ADDR_W'(b_row * N_SIZE + e_c) : '0;

    data_valid = (state == ARM);
    busy       = (state != IDLE);
    all_done   = (state == DONE);
  end

  always_comb begin
    state_nx  = state;
    elem_nx   = elem_cnt;
    col_nx    = tile_col_idx;
    row_nx    = tile_row_idx;
    last_elem = (32'(elem_cnt) == TILE_ELEMS - 1);
    last_col  = (32'(tile_col_idx) == TC - 1);
    last_row  = (32'(tile_row_idx) == TR - 1);
    case (state)
      IDLE: if (start) state_nx = ARM;
      ARM, STREAM: begin
        if (read_data) begin
          state_nx = STREAM;
          if (last_elem) begin
            elem_nx = '0;
            if (last_col) begin
              col_nx = '0;
              if (last_row) state_nx = DRAIN;
              else          row_nx   = tile_row_idx + 5'd1;
            end else begin
              col_nx = tile_col_idx + 5'd1;
            end
          end else begin
            elem_nx = elem_cnt + 1'b1;
          end
        end
      end
      DRAIN: state_nx = DONE;
      DONE: begin
        state_nx = IDLE;
        elem_nx  = '0;
        col_nx   = '0;
        row_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      elem_cnt     <= '0;
      tile_col_idx <= '0;
      tile_row_idx <= '0;
      out_valid    <= 1'b0;
      pad_a_q      <= 1'b0;
      pad_b_q      <= 1'b0;
      a_hold       <= '0;
      b_hold       <= '0;
    end else begin
      state        <= state_nx;
      elem_cnt     <= elem_nx;
      tile_col_idx <= col_nx;
      tile_row_idx <= row_nx;
      out_valid    <= serviced;
      pad_a_q      <= pad_a;
      pad_b_q      <= pad_b;
      if (out_valid) begin
        a_hold <= a_out;
        b_hold <= b_out;
      end
    end
  end

  // SRAM data arrives in the out_valid cycle, so the returned pair is taken
  // straight from the read port; the hold registers keep it stable afterwards.
  always_comb begin
    a_out = a_hold;
    b_out = b_hold;
    if (out_valid) begin
      a_out = pad_a_q ? '0 : mem_rdata_a;
      b_out = pad_b_q ? '0 : mem_rdata_b;
    end
  end

endmodule

// File: tb/tb_tile_data_feeder.sv
module tb_tile_data_feeder;

  typedef struct {
    int inst;
    int a;
    int b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start, rd, mem_rd_en, data_valid, out_valid, busy, all_done;
  logic [7:0] addr_a [3];
  logic [7:0] addr_b [3];
  logic [7:0] rdata_a [3];
  logic [7:0] rdata_b [3];
  logic [7:0] a_out [3];
  logic [7:0] b_out [3];
  logic [4:0] tcol [3];
  logic [4:0] trow [3];

  exp_t sbq[$];
  int   vectors = 0;
  int   fails = 0;
  int   beats [3] = '{0, 0, 0};
  int   done_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  // Default parameters (TC=4, TR=1)
  tile_data_feeder u_def (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .read_data(rd[0]),
    .data_valid(data_valid[0]), .mem_rd_en(mem_rd_en[0]),
    .mem_addr_a(addr_a[0]), .mem_addr_b(addr_b[0]),
    .mem_rdata_a(rdata_a[0]), .mem_rdata_b(rdata_b[0]),
    .a_out(a_out[0]), .b_out(b_out[0]), .out_valid(out_valid[0]),
    .tile_col_idx(tcol[0]), .tile_row_idx(trow[0]),
    .busy(busy[0]), .all_done(all_done[0]));

  // K_SIZE=6: TC=2, second column tile partially padded
  tile_data_feeder #(.K_SIZE(6)) u_pad (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .read_data(rd[1]),
    .data_valid(data_valid[1]), .mem_rd_en(mem_rd_en[1]),
    .mem_addr_a(addr_a[1]), .mem_addr_b(addr_b[1]),
    .mem_rdata_a(rdata_a[1]), .mem_rdata_b(rdata_b[1]),
    .a_out(a_out[1]), .b_out(b_out[1]), .out_valid(out_valid[1]),
    .tile_col_idx(tcol[1]), .tile_row_idx(trow[1]),
    .busy(busy[1]), .all_done(all_done[1]));

  // M_SIZE=8: TR=2
  tile_data_feeder #(.M_SIZE(8)) u_mr (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .read_data(rd[2]),
    .data_valid(data_valid[2]), .mem_rd_en(mem_rd_en[2]),
    .mem_addr_a(addr_a[2]), .mem_addr_b(addr_b[2]),
    .mem_rdata_a(rdata_a[2]), .mem_rdata_b(rdata_b[2]),
    .a_out(a_out[2]), .b_out(b_out[2]), .out_valid(out_valid[2]),
    .tile_col_idx(tcol[2]), .tile_row_idx(trow[2]),
    .busy(busy[2]), .all_done(all_done[2]));

  // Operand SRAMs: A[i]=i, B[i]=i+100; garbage when not enabled.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mem_rd_en[i]) begin
        rdata_a[i] <= addr_a[i];
        rdata_b[i] <= addr_b[i] + 8'd100;
      end else begin
        rdata_a[i] <= 8'hEE;
        rdata_b[i] <= 8'hEE;
      end
    end
  end

  // Monitor: pops the scoreboard whenever any instance presents a beat.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (all_done[i]) done_cnt[i]++;
      if (out_valid[i]) begin
        exp_t e;
        beats[i]++;
        vectors++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat inst=%0d got a=%0d b=%0d, none expected",
                   i, a_out[i], b_out[i]);
        end else begin
          e = sbq.pop_front();
          if (e.inst != i || int'(a_out[i]) != e.a || int'(b_out[i]) != e.b) begin
            fails++;
            $display("FAIL beat inst=%0d got a=%0d b=%0d, expected inst=%0d a=%0d b=%0d",
                     i, a_out[i], b_out[i], e.inst, e.a, e.b);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int kof(input int i);
    return (i == 1) ? 6 : 16;
  endfunction

  function automatic int mof(input int i);
    return (i == 2) ? 8 : 4;
  endfunction

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  // Request element n of the job on instance i and queue its expected pair.
  task automatic drive(input int i, input int n);
    exp_t e;
    int k, m, tcn, tile, el, tr, tc, r, c, ar, ac, br;
    k = kof(i); m = mof(i);
    tcn = (k + 3) / 4;
    tile = n / 16; el = n % 16;
    tr = tile / tcn; tc = tile % tcn;
    r = el / 4; c = el % 4;
    ar = tr * 4 + r; ac = tc * 4 + c; br = tc * 4 + r;
    e.inst = i;
    e.a = (ar < m && ac < k) ? ar * k + ac : 0;
    e.b = (br < k && c < 4) ? br * 4 + c + 100 : 0;
    sbq.push_back(e);
    rd[i] = 1'b1;
    #1;
  endtask

  task automatic run_range(input int i, input int first, input int last);
    for (int n = first; n <= last; n++) begin
      drive(i, n);
      tick();
    end
  endtask

  task automatic finish_job(input int i);
    int found;
    rd[i] = 1'b0;
    found = 0;
    for (int t = 0; t < 8 && found == 0; t++) begin
      tick();
      if (all_done[i]) found = 1;
    end
    chk("all_done_seen", found, 1);
    tick();
    chk("busy_after_done", int'(busy[i]), 0);
    chk("tile_col_cleared", int'(tcol[i]), 0);
    chk("scoreboard_drained", sbq.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    rd    = '0;
    tick();
    tick();
    // Reset state
    chk("rst_data_valid", int'(data_valid[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_out_valid", int'(out_valid[0]), 0);
    chk("rst_a_out", int'(a_out[0]), 0);
    chk("rst_mem_rd_en", int'(mem_rd_en[0]), 0);
    chk("rst_all_done", int'(all_done[0]), 0);
    rst_n = 1'b1;
    tick();

    // Full default job, read_data held continuously
    pulse_start(0);
    chk("arm_data_valid", int'(data_valid[0]), 1);
    chk("arm_busy", int'(busy[0]), 1);
    tick();
    chk("arm_wait_data_valid", int'(data_valid[0]), 1);
    for (int n = 0; n < 64; n++) begin
      drive(0, n);
      if (n == 21) begin
        chk("t1e5_addr_a", int'(addr_a[0]), 21);
        chk("t1e5_addr_b", int'(addr_b[0]), 21);
      end
      tick();
      if (n == 0) chk("data_valid_drop", int'(data_valid[0]), 0);
      if (n == 16) chk("tile_col_1", int'(tcol[0]), 1);
      if (n == 21) begin
        chk("t1e5_a_out", int'(a_out[0]), 21);
        chk("t1e5_b_out", int'(b_out[0]), 121);
      end
    end
    rd[0] = 1'b0;
    chk("drain_no_done", int'(all_done[0]), 0);
    tick();
    chk("all_done_pulse", int'(all_done[0]), 1);
    tick();
    chk("all_done_clear", int'(all_done[0]), 0);
    chk("busy_clear", int'(busy[0]), 0);
    chk("beat_count", beats[0], 64);
    chk("done_count", done_cnt[0], 1);
    chk("sb_empty_job1", sbq.size(), 0);

    // read_data in IDLE is ignored
    rd[0] = 1'b1;
    #1;
    chk("idle_rd_en", int'(mem_rd_en[0]), 0);
    tick();
    chk("idle_out_valid", int'(out_valid[0]), 0);
    rd[0] = 1'b0;
    tick();

    // Stall pattern 1,0,1,0,... and start while busy
    begin
      int idx;
      int val;
      idx = 0;
      pulse_start(0);
      for (int s = 0; s < 8; s++) begin
        val = (s % 2 == 0) ? 1 : 0;
        if (val == 1) begin
          drive(0, idx);
          chk("stall_addr_a", int'(addr_a[0]), idx);
          idx++;
        end else begin
          rd[0] = 1'b0;
          #1;
          chk("stall_rd_en", int'(mem_rd_en[0]), 0);
        end
        tick();
        chk("stall_out_valid", int'(out_valid[0]), val);
      end
      drive(0, 4);
      start[0] = 1'b1;
      chk("elem4_addr_a", int'(addr_a[0]), 16);
      tick();
      start[0] = 1'b0;
      chk("busy_start_dv", int'(data_valid[0]), 0);
      chk("busy_start_busy", int'(busy[0]), 1);
      drive(0, 5);
      chk("busy_start_next_addr", int'(addr_a[0]), 17);
      tick();
      run_range(0, 6, 63);
      finish_job(0);
    end

    // Asynchronous reset at element 7 of tile 2
    pulse_start(0);
    run_range(0, 0, 38);
    drive(0, 39);
    chk("t2e7_addr_a", int'(addr_a[0]), 27);
    tick();
    rd[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid[0]), 0);
    chk("arst_a_out", int'(a_out[0]), 0);
    chk("arst_busy", int'(busy[0]), 0);
    chk("arst_tile_col", int'(tcol[0]), 0);
    sbq.delete();
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start(0);
    drive(0, 0);
    chk("restart_addr_a", int'(addr_a[0]), 0);
    chk("restart_tile_col", int'(tcol[0]), 0);
    tick();
    run_range(0, 1, 63);
    finish_job(0);

    // Padding instance (K_SIZE=6)
    pulse_start(1);
    for (int n = 0; n < 32; n++) begin
      drive(1, n);
      if (n == 18) begin
        chk("pad_a_addr", int'(addr_a[1]), 0);
        chk("pad_a_rd_en", int'(mem_rd_en[1]), 1);
        chk("pad_a_addr_b", int'(addr_b[1]), 18);
      end
      if (n == 24) begin
        chk("pad_b_addr_a", int'(addr_a[1]), 16);
        chk("pad_b_addr_b", int'(addr_b[1]), 0);
        chk("pad_b_rd_en", int'(mem_rd_en[1]), 1);
      end
      if (n == 26) chk("pad_both_rd_en", int'(mem_rd_en[1]), 0);
      tick();
      if (n == 18) begin
        chk("pad_a_out", int'(a_out[1]), 0);
        chk("pad_a_b_out", int'(b_out[1]), 118);
        chk("pad_a_ov", int'(out_valid[1]), 1);
      end
      if (n == 24) begin
        chk("pad_b_out", int'(b_out[1]), 0);
        chk("pad_b_a_out", int'(a_out[1]), 16);
      end
      if (n == 26) begin
        chk("pad_both_ov", int'(out_valid[1]), 1);
        chk("pad_both_a", int'(a_out[1]), 0);
        chk("pad_both_b", int'(b_out[1]), 0);
      end
    end
    finish_job(1);

    // Multi-row instance (M_SIZE=8)
    pulse_start(2);
    run_range(2, 0, 63);
    chk("mr_row_idx", int'(trow[2]), 1);
    chk("mr_col_idx", int'(tcol[2]), 0);
    drive(2, 64);
    chk("mr_addr_a", int'(addr_a[2]), 64);
    tick();
    run_range(2, 65, 127);
    finish_job(2);
    chk("mr_beats", beats[2], 128);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
